cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
Multi-cycle fetch/execute controller for the 4-bit CPU. It owns the program counter, drives the 4-bit instruction ROM address, and latches the 8-bit instruction word. It executes against registers A and B, the carry flag and the output port. It sits between the combinational instruction ROM and the board I/O, and provides run/single-step control.

Parameters:
RESET_PC, 4'h0, program counter value loaded on reset
OPW, 4, opcode field width (instruction bits [7:4]); immediate is bits [3:0]

Ports:
CLK  in  1  system clock, all state changes on rising edge
RST  in  1  asynchronous, active-high reset
RUN  in  1  level; 1 = free-running execution
STEP  in  1  single-cycle pulse; executes exactly one instruction while RUN=0
ROM_ADDR  out  4  instruction address, equals PC register (registered, no combinational path from inputs)
ROM_DATA  in  8  instruction word from combinational ROM, valid same cycle as ROM_ADDR
IN_PORT  in  4  external input switches
OUT_PORT  out  4  registered output port
CARRY  out  1  carry flag
BUSY  out  1  1 while state is FETCH or EXEC
INSTR_DONE  out  1  one-cycle pulse in the cycle after an EXEC completes

Behaviour:
- Reset (async): PC=RESET_PC, A=B=0, C=0, IR=0, OUT_PORT=0, INSTR_DONE=0, state=IDLE, BUSY=0.
- States: IDLE, FETCH, EXEC.
- IDLE: if RUN=1 -> FETCH. Else if STEP=1 -> FETCH, with a step flag set. Else stay. RUN and STEP both high: treat as RUN and clear the step flag.
- FETCH (1 cycle): IR <= ROM_DATA (addressed by PC) -> EXEC.
- EXEC (1 cycle): perform the op, update PC and C, pulse INSTR_DONE next cycle. Then go to FETCH if RUN=1 and the step flag is clear, else go to IDLE and clear the step flag.
- Latency: 2 cycles per instruction in run mode. A STEP pulse produces INSTR_DONE 3 cycles later.
- RUN falling mid-instruction: the current instruction completes, then the block goes IDLE. No partial state update.
- STEP asserted while BUSY: ignored.
- Opcodes (IR[7:4]), Im = IR[3:0]:
  - 0000 ADD A,Im
  - 0101 ADD B,Im
  - 0011 MOV A,Im
  - 0111 MOV B,Im
  - 0001 MOV A,B
  - 0100 MOV B,A
  - 0010 IN A
  - 0110 IN B
  - 1001 OUT B
  - 1011 OUT Im
  - 1111 JMP Im
  - 1110 JNC Im
- ADD: 5-bit sum. The destination gets sum[3:0] and C <= sum[4].
- Every non-ADD instruction clears C, including JNC after its test.
- JNC: PC <= Im if C==0 (C sampled before the clear), else PC+1.
- JMP: PC <= Im.
- All other ops: PC <= PC+1, modulo 16; PC 4'hF wraps to 4'h0 with no flag.
- Undefined opcodes execute as a NOP: PC+1 and C cleared.
- IN_PORT is sampled only in the EXEC cycle. OUT_PORT changes only in EXEC of OUT instructions.
- Reset asserted in any state aborts immediately. No register retains a partial update.

Decomposition:
- Shared package cpu_pkg:
  - opcode localparams (OP_ADD_A ... OP_JNC)
  - state encoding (ST_IDLE, ST_FETCH, ST_EXEC)
  - instruction field slice constants
- One natural sub-module, cpu_decode: purely combinational. Maps IR to control signals (dst_sel, src_sel, alu_add, load_out, jump, jump_cond). The sequencer keeps all registers and the FSM.

Test Plan:
- Reset mid-EXEC with A=5, PC=9, OUT=3 -> next edge shows ROM_ADDR=0, OUT_PORT=0, CARRY=0, BUSY=0; holds while RST=1.
- RUN=1 with ROM {0:8'h73 MOV B,3; 1:8'h90 OUT B; 2:8'h5E ADD B,14; 3:8'hE1 JNC 1; 4:8'hF4 JMP 4} -> after 2nd INSTR_DONE OUT_PORT=3. ADD gives B=1, C=1. JNC falls through to PC=4 and C=0. PC then stays 4.
- JNC taken: ROM {0:8'h01 ADD A,1; 1:8'hE0 JNC 0} -> PC alternates 0,1,0. A increments every 4 cycles. After A=15 the ADD makes A=0, C=1 and JNC goes to PC=2.
- STEP pulse with RUN=0 -> exactly one INSTR_DONE 3 cycles later, PC+1, BUSY high for 2 cycles. STEP during BUSY is ignored (PC advances once only).
- IN A with IN_PORT=4'hA, then OUT Im at 4'h5 and an undefined opcode 8'h8x -> A=A after IN. OUT_PORT=5. Undefined op gives PC+1 and C=0, other registers unchanged.
- PC wrap: 16 NOP-equivalent MOV A,0 words in free run -> ROM_ADDR sequence 0..15 then 0, no stall.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU: opcodes, FSM states, decode select types
// and instruction field positions.
package cpu_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_EXEC} state_e;
  typedef enum logic [1:0] {DST_NONE, DST_A, DST_B} dst_e;
  typedef enum logic [1:0] {SRC_IMM, SRC_A, SRC_B, SRC_IN} src_e;

  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 4;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_MOV_AI = 4'b0011;
  localparam logic [3:0] OP_MOV_BI = 4'b0111;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_I  = 4'b1011;
  localparam logic [3:0] OP_JMP    = 4'b1111;
  localparam logic [3:0] OP_JNC    = 4'b1110;

endpackage

// File: rtl/cpu_decode.sv
// Combinational instruction decoder: turns the opcode field into datapath controls.
// Undefined opcodes decode to all-inactive controls, which the sequencer runs as a NOP.
module cpu_decode
  import cpu_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] opcode,
  output dst_e           dst_sel,
  output src_e           src_sel,
  output logic           alu_add,
  output logic           load_out,
  output logic           jump,
  output logic           jump_cond
);

  always_comb begin
    dst_sel   = DST_NONE;
    src_sel   = SRC_IMM;
    alu_add   = 1'b0;
    load_out  = 1'b0;
    jump      = 1'b0;
    jump_cond = 1'b0;
    case (opcode)
      OP_ADD_A:  begin dst_sel = DST_A; alu_add = 1'b1; end
      OP_ADD_B:  begin dst_sel = DST_B; alu_add = 1'b1; end
      OP_MOV_AI: dst_sel = DST_A;
      OP_MOV_BI: dst_sel = DST_B;
      OP_MOV_AB: begin dst_sel = DST_A; src_sel = SRC_B; end
      OP_MOV_BA: begin dst_sel = DST_B; src_sel = SRC_A; end
      OP_IN_A:   begin dst_sel = DST_A; src_sel = SRC_IN; end
      OP_IN_B:   begin dst_sel = DST_B; src_sel = SRC_IN; end
      OP_OUT_B:  begin load_out = 1'b1; src_sel = SRC_B; end
      OP_OUT_I:  load_out = 1'b1;
      OP_JMP:    jump = 1'b1;
      OP_JNC:    begin jump = 1'b1; jump_cond = 1'b1; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/execute controller for the 4-bit CPU: owns PC, IR, A, B, carry and the
// output port, and provides free-run and single-step control.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [3:0] RESET_PC = 4'h0,
  parameter int         OPW      = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RUN,
  input  logic       STEP,
  output logic [3:0] ROM_ADDR,
  input  logic [7:0] ROM_DATA,
  input  logic [3:0] IN_PORT,
  output logic [3:0] OUT_PORT,
  output logic       CARRY,
  output logic       BUSY,
  output logic       INSTR_DONE
);

  state_e     state;
  logic [3:0] pc;
  logic [3:0] reg_a;
  logic [3:0] reg_b;
  logic [7:0] ir;
  logic       step_flag;

  dst_e       dst_sel;
  src_e       src_sel;
  logic       alu_add;
  logic       load_out;
  logic       jump;
  logic       jump_cond;

  logic [3:0] imm;
  logic [3:0] operand;
  logic [3:0] dst_val;
  logic [4:0] sum;
  logic [3:0] result;
  logic       take_jump;

  cpu_decode #(.OPW(OPW)) u_decode (
    .opcode    (ir[OP_MSB:OP_LSB]),
    .dst_sel   (dst_sel),
    .src_sel   (src_sel),
    .alu_add   (alu_add),
    .load_out  (load_out),
    .jump      (jump),
    .jump_cond (jump_cond)
  );

  // ADD accumulates into its destination; every other writer just passes the operand.
  always_comb begin
    imm = ir[IMM_MSB:IMM_LSB];
    case (src_sel)
      SRC_A:   operand = reg_a;
      SRC_B:   operand = reg_b;
      SRC_IN:  operand = IN_PORT;
      default: operand = imm;
    endcase
    dst_val   = (dst_sel == DST_B) ? reg_b : reg_a;
    sum       = {1'b0, dst_val} + {1'b0, operand};
    result    = alu_add ? sum[3:0] : operand;
    take_jump = jump && !(jump_cond && CARRY);
  end

  assign ROM_ADDR = pc;
  assign BUSY     = (state != ST_IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      reg_a      <= 4'h0;
      reg_b      <= 4'h0;
      ir         <= 8'h00;
      step_flag  <= 1'b0;
      OUT_PORT   <= 4'h0;
      CARRY      <= 1'b0;
      INSTR_DONE <= 1'b0;
    end else begin
      INSTR_DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (RUN) begin
            state     <= ST_FETCH;
            step_flag <= 1'b0;
          end else if (STEP) begin
            state     <= ST_FETCH;
            step_flag <= 1'b1;
          end
        end
        ST_FETCH: begin
          ir    <= ROM_DATA;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (dst_sel == DST_A) reg_a <= result;
          if (dst_sel == DST_B) reg_b <= result;
          if (load_out) OUT_PORT <= operand;
          // JNC tests the carry as it stood before this instruction clears it.
          CARRY      <= alu_add ? sum[4] : 1'b0;
          pc         <= take_jump ? imm : pc + 4'h1;
          INSTR_DONE <= 1'b1;
          step_flag  <= 1'b0;
          state      <= (RUN && !step_flag) ? ST_FETCH : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: a behavioural CPU model predicts PC, OUT and
// carry per instruction; a monitor compares them on every INSTR_DONE pulse.
module tb_cpu_sequencer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RUN;
  logic       STEP;
  logic [3:0] ROM_ADDR;
  logic [7:0] ROM_DATA;
  logic [3:0] IN_PORT;
  logic [3:0] OUT_PORT;
  logic       CARRY;
  logic       BUSY;
  logic       INSTR_DONE;

  logic [7:0] rom [16];
  assign ROM_DATA = rom[ROM_ADDR];

  always #5 CLK = ~CLK;

  cpu_sequencer dut (
    .CLK        (CLK),
    .RST        (RST),
    .RUN        (RUN),
    .STEP       (STEP),
    .ROM_ADDR   (ROM_ADDR),
    .ROM_DATA   (ROM_DATA),
    .IN_PORT    (IN_PORT),
    .OUT_PORT   (OUT_PORT),
    .CARRY      (CARRY),
    .BUSY       (BUSY),
    .INSTR_DONE (INSTR_DONE)
  );

  typedef struct {
    int pc;
    int outp;
    int carry;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   m_pc, m_a, m_b, m_c, m_out;

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void modelReset();
    m_pc = 0; m_a = 0; m_b = 0; m_c = 0; m_out = 0;
  endfunction

  // Architectural model: one call executes the instruction at the model PC.
  function automatic void modelExec(input int in_val);
    int ir      = int'(rom[m_pc]);
    int op      = ir / 16;
    int im      = ir % 16;
    int old_c   = m_c;
    int next_pc = (m_pc + 1) % 16;
    m_c = 0;
    case (op)
      0:  begin m_a = m_a + im; m_c = m_a / 16; m_a = m_a % 16; end
      5:  begin m_b = m_b + im; m_c = m_b / 16; m_b = m_b % 16; end
      3:  m_a = im;
      7:  m_b = im;
      1:  m_a = m_b;
      4:  m_b = m_a;
      2:  m_a = in_val;
      6:  m_b = in_val;
      9:  m_out = m_b;
      11: m_out = im;
      15: next_pc = im;
      14: if (old_c == 0) next_pc = im;
      default: ;
    endcase
    m_pc = next_pc;
    sb.push_back('{m_pc, m_out, m_c});
  endfunction

  always @(negedge CLK) begin
    if (!RST && INSTR_DONE) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_done: got pulse expected none at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("pc",    int'(ROM_ADDR), mon_e.pc);
        checkOutput("out",   int'(OUT_PORT), mon_e.outp);
        checkOutput("carry", int'(CARRY),    mon_e.carry);
      end
    end
  end

  // run_mode=1: hold RUN for exactly n instructions with STEP noise; else one STEP.
  task automatic applyStimulus(input bit run_mode, input int n, input logic [3:0] in_val);
    IN_PORT = in_val;
    if (run_mode) begin
      for (int k = 0; k < n; k++) modelExec(int'(in_val));
      @(negedge CLK);
      RUN  = 1'b1;
      STEP = 1'($urandom_range(0, 1));
      for (int k = 0; k < 2 * n; k++) begin
        @(negedge CLK);
        checkOutput("busy_run", int'(BUSY), 1);
        STEP = (k < 2 * n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      RUN = 1'b0;
      repeat (3) @(negedge CLK);
      checkOutput("idle_after_run", int'(BUSY), 0);
    end else begin
      modelExec(int'(in_val));
      @(negedge CLK);
      STEP = 1'b1;
      @(negedge CLK);
      checkOutput("busy_fetch", int'(BUSY), 1);
      STEP = 1'($urandom_range(0, 1));
      @(negedge CLK);
      checkOutput("busy_exec", int'(BUSY), 1);
      STEP = 1'b0;
      @(negedge CLK);
      checkOutput("step_idle", int'(BUSY), 0);
      checkOutput("step_done", int'(INSTR_DONE), 1);
      repeat (2) @(negedge CLK);
      checkOutput("step_single", int'(BUSY), 0);
    end
    checkOutput("drain", sb.size(), 0);
  endtask

  task automatic pulseReset();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    modelReset();
  endtask

  task automatic fillRom(input logic [7:0] val);
    for (int i = 0; i < 16; i++) rom[i] = val;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RST = 1'b1; RUN = 1'b0; STEP = 1'b0; IN_PORT = 4'h0;
    fillRom(8'h30);
    modelReset();
    #12;
    checkOutput("rst_addr",  int'(ROM_ADDR), 0);
    checkOutput("rst_out",   int'(OUT_PORT), 0);
    checkOutput("rst_carry", int'(CARRY), 0);
    checkOutput("rst_busy",  int'(BUSY), 0);
    checkOutput("rst_done",  int'(INSTR_DONE), 0);
    @(negedge CLK);
    RST = 1'b0;

    // MOV B,3; OUT B; ADD B,14; JNC 1 (falls through); JMP 4 forever
    rom[0] = 8'h73; rom[1] = 8'h90; rom[2] = 8'h5E; rom[3] = 8'hE1; rom[4] = 8'hF4;
    applyStimulus(1'b1, 7, 4'h0);

    // ADD A,1 / JNC 0 loop until the carry breaks out to PC 2
    pulseReset();
    fillRom(8'h30);
    rom[0] = 8'h01; rom[1] = 8'hE0;
    applyStimulus(1'b1, 36, 4'h0);

    // IN A, OUT 5, undefined op, MOV B,A, OUT B, single-stepped
    pulseReset();
    fillRom(8'h30);
    rom[0] = 8'h20; rom[1] = 8'hB5; rom[2] = 8'h85; rom[3] = 8'h40; rom[4] = 8'h90;
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1, 4'hA);

    // PC wrap through all 16 addresses
    pulseReset();
    fillRom(8'h30);
    applyStimulus(1'b1, 17, 4'h3);

    for (int p = 0; p < 30; p++) begin
      for (int i = 0; i < 16; i++) rom[i] = 8'($urandom_range(0, 255));
      applyStimulus(1'($urandom_range(0, 1)), $urandom_range(1, 6), 4'($urandom_range(0, 15)));
    end

    // Reset during the EXEC of the instruction at PC 9
    pulseReset();
    fillRom(8'h30);
    rom[0] = 8'h35; rom[1] = 8'hB3; rom[2] = 8'hF9;
    for (int k = 0; k < 3; k++) modelExec(0);
    @(negedge CLK);
    RUN = 1'b1;
    repeat (8) @(negedge CLK);
    checkOutput("pre_rst_busy", int'(BUSY), 1);
    checkOutput("pre_rst_out",  int'(OUT_PORT), 3);
    #1 RST = 1'b1;
    #1;
    checkOutput("abort_addr",  int'(ROM_ADDR), 0);
    checkOutput("abort_out",   int'(OUT_PORT), 0);
    checkOutput("abort_carry", int'(CARRY), 0);
    checkOutput("abort_busy",  int'(BUSY), 0);
    checkOutput("abort_done",  int'(INSTR_DONE), 0);
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("hold_addr", int'(ROM_ADDR), 0);
    checkOutput("hold_busy", int'(BUSY), 0);
    @(negedge CLK);
    RUN = 1'b0;
    RST = 1'b0;
    modelReset();
    checkOutput("drain_final", sb.size(), 0);

    repeat (2) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
